// File: rtl/satarx_scrambler_wide.sv
// Multi-dword-per-beat SATA frame (de)scrambler with a 16-bit Galois LFSR.
// The LFSR is reseeded at every frame start; mode and dword count are tracked per frame.
module satarx_scrambler_wide #(
  parameter int          NW           = 2,
  parameter logic [15:0] POLYNOMIAL   = 16'ha011,
  parameter logic [15:0] INITIAL      = 16'hffff,
  parameter bit          OPT_LOWPOWER = 1'b1
) (
  input  logic            S_AXI_ACLK,
  input  logic            S_AXI_ARESETN,
  input  logic            i_cfg_scrambler_en,
  input  logic            S_AXIS_TVALID,
  output logic            S_AXIS_TREADY,
  input  logic [32*NW-1:0] S_AXIS_TDATA,
  input  logic [NW-1:0]   S_AXIS_TKEEP,
  input  logic            S_AXIS_TLAST,
  output logic            M_AXIS_TVALID,
  input  logic            M_AXIS_TREADY,
  output logic [32*NW-1:0] M_AXIS_TDATA,
  output logic [NW-1:0]   M_AXIS_TKEEP,
  output logic            M_AXIS_TLAST,
  output logic [15:0]     o_frame_words,
  output logic            o_active
);

  localparam int KW = $clog2(NW + 1);

  logic [15:0]      fill;
  logic [15:0]      seed;
  logic [15:0]      fill_nxt;
  logic [47:0]      step;
  logic [KW-1:0]    kcnt;
  logic [32*NW-1:0] data_nxt;
  logic [16:0]      words_sum;
  logic             accept;

  // Returns {fill after 32 steps, 32 prn bits with bit 0 first in time}.
  function automatic logic [47:0] lfsr_dword(input logic [15:0] f_in);
    logic [15:0] f;
    logic [31:0] prn;
    f   = f_in;
    prn = '0;
    for (int b = 0; b < 32; b++) begin
      prn[b] = f[15];
      f      = {f[14:0], 1'b0} ^ (f[15] ? POLYNOMIAL : 16'h0000);
    end
    return {f, prn};
  endfunction

  assign S_AXIS_TREADY = !M_AXIS_TVALID || M_AXIS_TREADY;
  assign accept        = S_AXIS_TVALID && S_AXIS_TREADY;

  always_comb begin
    kcnt     = '0;
    step     = '0;
    data_nxt = '0;
    for (int i = 0; i < NW; i++) begin
      kcnt = kcnt + KW'(S_AXIS_TKEEP[i]);
    end
    // A frame start ignores the fill register so mode is fixed for the whole frame.
    seed     = o_active ? fill : (i_cfg_scrambler_en ? INITIAL : 16'h0000);
    fill_nxt = seed;
    for (int i = 0; i < NW; i++) begin
      step = lfsr_dword(fill_nxt);
      if (i < int'(kcnt)) begin
        data_nxt[32*i +: 32] = S_AXIS_TDATA[32*i +: 32] ^ step[31:0];
        fill_nxt             = step[47:32];
      end else if (!OPT_LOWPOWER) begin
        data_nxt[32*i +: 32] = S_AXIS_TDATA[32*i +: 32];
      end
    end
    words_sum = {1'b0, o_frame_words} + 17'(kcnt);
  end

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      M_AXIS_TVALID <= 1'b0;
      M_AXIS_TDATA  <= '0;
      M_AXIS_TKEEP  <= '0;
      M_AXIS_TLAST  <= 1'b0;
      fill          <= INITIAL;
      o_frame_words <= 16'h0000;
      o_active      <= 1'b0;
    end else begin
      if (accept) begin
        M_AXIS_TVALID <= 1'b1;
        M_AXIS_TDATA  <= data_nxt;
        M_AXIS_TKEEP  <= S_AXIS_TKEEP;
        M_AXIS_TLAST  <= S_AXIS_TLAST;
        fill          <= S_AXIS_TLAST ? INITIAL : fill_nxt;
        o_active      <= !S_AXIS_TLAST;
        if (!o_active) begin
          o_frame_words <= 16'(kcnt);
        end else begin
          o_frame_words <= words_sum[16] ? 16'hffff : words_sum[15:0];
        end
      end else if (M_AXIS_TREADY) begin
        M_AXIS_TVALID <= 1'b0;
        if (OPT_LOWPOWER) begin
          M_AXIS_TDATA <= '0;
          M_AXIS_TKEEP <= '0;
          M_AXIS_TLAST <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_satarx_scrambler_wide.sv
// Directed bench for satarx_scrambler_wide: an NW=2 instance and an NW=1 instance
// share clock, reset and scrambler enable.
module tb_satarx_scrambler_wide;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;

  logic        s_valid, s_ready, s_last, m_valid, m_ready, m_last, act;
  logic [63:0] s_data, m_data;
  logic [1:0]  s_keep, m_keep;
  logic [15:0] fw;

  logic        s1_valid, s1_ready, s1_last, m1_valid, m1_ready, m1_last, act1;
  logic [31:0] s1_data, m1_data;
  logic [0:0]  s1_keep, m1_keep;
  logic [15:0] fw1;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] gfill;

  always #5 clk = ~clk;

  satarx_scrambler_wide #(.NW(2)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_cfg_scrambler_en(en),
    .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready), .S_AXIS_TDATA(s_data),
    .S_AXIS_TKEEP(s_keep), .S_AXIS_TLAST(s_last),
    .M_AXIS_TVALID(m_valid), .M_AXIS_TREADY(m_ready), .M_AXIS_TDATA(m_data),
    .M_AXIS_TKEEP(m_keep), .M_AXIS_TLAST(m_last),
    .o_frame_words(fw), .o_active(act)
  );

  satarx_scrambler_wide #(.NW(1)) dut1 (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_cfg_scrambler_en(en),
    .S_AXIS_TVALID(s1_valid), .S_AXIS_TREADY(s1_ready), .S_AXIS_TDATA(s1_data),
    .S_AXIS_TKEEP(s1_keep), .S_AXIS_TLAST(s1_last),
    .M_AXIS_TVALID(m1_valid), .M_AXIS_TREADY(m1_ready), .M_AXIS_TDATA(m1_data),
    .M_AXIS_TKEEP(m1_keep), .M_AXIS_TLAST(m1_last),
    .o_frame_words(fw1), .o_active(act1)
  );

  // Golden scrambler sequence: next 32 prn bits, bit 0 first in time.
  function automatic logic [31:0] gnext();
    logic [31:0] p;
    p = '0;
    for (int b = 0; b < 32; b++) begin
      p[b]  = gfill[15];
      gfill = {gfill[14:0], 1'b0} ^ (gfill[15] ? 16'ha011 : 16'h0000);
    end
    return p;
  endfunction

  task automatic send2(input logic [63:0] d, input logic [1:0] k, input logic l);
    if (!(k == 2'b01 || k == 2'b11)) begin
      errors++;
      $display("FAIL keep_legal illegal TKEEP %b driven", k);
    end
    s_valid = 1'b1; s_data = d; s_keep = k; s_last = l;
    @(negedge clk);
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
  endtask

  task automatic send1(input logic [31:0] d, input logic l);
    s1_valid = 1'b1; s1_data = d; s1_keep = 1'b1; s1_last = l;
    @(negedge clk);
    s1_valid = 1'b0; s1_data = '0; s1_keep = '0; s1_last = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_tvalid got %b exp 0", m_valid); end
    checks++; if ({m_data, m_keep, m_last} !== 67'h0) begin errors++; $display("FAIL reset_outputs got %h exp 0", {m_data, m_keep, m_last}); end
    checks++; if (fw !== 16'h0 || act !== 1'b0) begin errors++; $display("FAIL reset_frame got fw=%h act=%b exp 0/0", fw, act); end
    checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_tready got %b exp 1", s_ready); end
    checks++; if (m1_valid !== 1'b0 || m1_data !== 32'h0) begin errors++; $display("FAIL reset_nw1 got v=%b d=%h exp 0", m1_valid, m1_data); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scramble_nw1();
    logic [31:0] e;
    en = 1'b1; m1_ready = 1'b1; gfill = 16'hffff;
    for (int i = 0; i < 4; i++) begin
      send1(32'h0, i == 3);
      e = gnext();
      if (i == 0) begin
        checks++; if (m1_data !== 32'hc2d2768d) begin errors++; $display("FAIL nw1_first_dword got %h exp c2d2768d", m1_data); end
      end
      checks++; if (m1_data !== e || m1_valid !== 1'b1) begin errors++; $display("FAIL nw1_dword%0d got %h v=%b exp %h", i, m1_data, m1_valid, e); end
      checks++; if (m1_last !== (i == 3) || act1 !== (i != 3)) begin errors++; $display("FAIL nw1_last_active%0d got %b/%b", i, m1_last, act1); end
    end
    checks++; if (fw1 !== 16'd4) begin errors++; $display("FAIL nw1_frame_words got %0d exp 4", fw1); end
    @(negedge clk);
    checks++; if (m1_valid !== 1'b0 || m1_data !== 32'h0) begin errors++; $display("FAIL nw1_idle got v=%b d=%h exp 0/0", m1_valid, m1_data); end
  endtask

  task automatic test_passthrough();
    en = 1'b0;
    send1(32'h12345678, 1'b0);
    checks++; if (m1_data !== 32'h12345678 || fw1 !== 16'd1) begin errors++; $display("FAIL pass_beat0 got %h fw=%0d exp 12345678/1", m1_data, fw1); end
    send1(32'hdeadbeef, 1'b1);
    checks++; if (m1_data !== 32'hdeadbeef || fw1 !== 16'd2) begin errors++; $display("FAIL pass_beat1 got %h fw=%0d exp deadbeef/2", m1_data, fw1); end
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_partial_keep();
    logic [1:0]  k;
    logic [31:0] g0, g1;
    en = 1'b1; m_ready = 1'b1; gfill = 16'hffff;
    for (int b = 0; b < 3; b++) begin
      k = (b == 2) ? 2'b01 : 2'b11;
      send2(64'h0, k, b == 2);
      g0 = gnext();
      g1 = k[1] ? gnext() : 32'h0;
      checks++; if (m_data !== {g1, g0}) begin errors++; $display("FAIL keep_beat%0d got %h exp %h", b, m_data, {g1, g0}); end
      checks++; if (m_keep !== k || m_last !== (b == 2)) begin errors++; $display("FAIL keep_ctl%0d got %b/%b", b, m_keep, m_last); end
    end
    checks++; if (fw !== 16'd5 || act !== 1'b0) begin errors++; $display("FAIL keep_frame got fw=%0d act=%b exp 5/0", fw, act); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [63:0] d, e;
    logic [1:0]  k;
    logic [31:0] g0, g1;
    en = 1'b1; m_ready = 1'b1; gfill = 16'hffff;
    for (int b = 0; b < 5; b++) begin
      if (b == 1) en = 1'b0;
      d = {32'h11110000 + 32'(b), 32'ha5a50000 + 32'(b)};
      k = (b == 4) ? 2'b01 : 2'b11;
      send2(d, k, b == 2 || b == 4);
      if (b < 3) begin
        g0 = gnext(); g1 = gnext();
        e = d ^ {g1, g0};
      end else begin
        e = (b == 4) ? {32'h0, d[31:0]} : d;
      end
      checks++; if (m_data !== e) begin errors++; $display("FAIL b2b_beat%0d got %h exp %h", b, m_data, e); end
    end
    checks++; if (fw !== 16'd3 || act !== 1'b0) begin errors++; $display("FAIL b2b_frame got fw=%0d act=%b exp 3/0", fw, act); end
    en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    logic [64:0] expq[$];
    logic [64:0] sv, ev;
    logic        stalled, acc;
    logic [31:0] g0, g1;
    int          sent, recv;
    sent = 0; recv = 0; stalled = 1'b0; sv = '0; gfill = 16'hffff; en = 1'b1;
    s_valid = 1'b1; s_keep = 2'b11; s_data = {$urandom, $urandom}; s_last = 1'b0;
    for (int cyc = 0; cyc < 6000 && recv < 1000; cyc++) begin
      m_ready = 1'($urandom_range(0, 1));
      #1;
      if (stalled) begin
        checks++;
        if ({m_valid, m_last, m_data} !== {1'b1, sv}) begin errors++; $display("FAIL bp_stall got %h exp %h", {m_valid, m_last, m_data}, {1'b1, sv}); end
      end
      if (m_valid && m_ready) begin
        checks++;
        if (expq.size() == 0) begin
          errors++; $display("FAIL bp_extra got beat %h exp none", m_data);
        end else begin
          ev = expq.pop_front();
          if ({m_last, m_data} !== ev) begin errors++; $display("FAIL bp_beat%0d got %h exp %h", recv, {m_last, m_data}, ev); end
        end
        recv++;
      end
      stalled = m_valid && !m_ready;
      sv  = {m_last, m_data};
      acc = s_valid && s_ready;
      if (acc) begin
        g0 = gnext(); g1 = gnext();
        expq.push_back({s_last, s_data ^ {g1, g0}});
        if (s_last) gfill = 16'hffff;
        sent++;
      end
      @(negedge clk);
      if (acc) begin
        if (sent < 1000) begin
          s_data = {$urandom, $urandom};
          s_last = (sent % 7 == 6) || (sent == 999);
        end else begin
          s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0;
        end
      end
    end
    checks++;
    if (recv != 1000 || expq.size() != 0) begin errors++; $display("FAIL bp_count got %0d beats exp 1000 (left %0d)", recv, expq.size()); end
    m_ready = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_midframe();
    logic [31:0] g0, g1;
    en = 1'b1; m_ready = 1'b1;
    send2(64'h0123456789abcdef, 2'b11, 1'b0);
    send2(64'hfedcba9876543210, 2'b11, 1'b0);
    checks++; if (act !== 1'b1 || fw !== 16'd4) begin errors++; $display("FAIL rst_pre got act=%b fw=%0d exp 1/4", act, fw); end
    rst_n = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0 || act !== 1'b0 || fw !== 16'h0) begin errors++; $display("FAIL rst_async got v=%b act=%b fw=%0d exp 0/0/0", m_valid, act, fw); end
    @(negedge clk);
    rst_n = 1'b1;
    gfill = 16'hffff;
    send2(64'h0, 2'b11, 1'b1);
    g0 = gnext(); g1 = gnext();
    checks++; if (m_data !== {g1, g0}) begin errors++; $display("FAIL rst_reseed got %h exp %h", m_data, {g1, g0}); end
    checks++; if (fw !== 16'd2 || act !== 1'b0) begin errors++; $display("FAIL rst_frame got fw=%0d act=%b exp 2/0", fw, act); end
  endtask

  initial begin
    en = 1'b1;
    s_valid = 1'b0; s_data = '0; s_keep = '0; s_last = 1'b0; m_ready = 1'b0;
    s1_valid = 1'b0; s1_data = '0; s1_keep = '0; s1_last = 1'b0; m1_ready = 1'b0;
    test_reset();
    test_scramble_nw1();
    test_passthrough();
    test_partial_keep();
    test_back_to_back();
    test_backpressure();
    test_reset_midframe();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
